mem_master: RTL and testbench
=============================

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter LEN_W, default 3, burst-length field width; req_len = beats-1, so bursts are 1..8 beats.
REQ-004 mem_clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  request offered.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_we  in  1  1 = single-word store, 0 = burst load.
REQ-009 req_addr  in  ADDR_W  base word address.
REQ-010 req_len  in  LEN_W  beats-1, loads only; ignored for stores.
REQ-011 req_wdata  in  DATA_W  store data.
REQ-012 resp_valid  out  1  one load beat valid this cycle.
REQ-013 resp_data  out  DATA_W  load beat data.
REQ-014 resp_last  out  1  final beat of the burst, qualified by resp_valid.
REQ-015 busy  out  1  FSM is not in IDLE, or read responses are still pending.
REQ-016 err  out  1  one-cycle bound-violation pulse.
REQ-017 mem_dwe  out  1  memory write enable.
REQ-018 mem_addr  out  ADDR_W  memory address.
REQ-019 mem_wdata  out  DATA_W  memory write data.
REQ-020 mem_rdata  in  DATA_W  memory read data, registered in the memory, valid the cycle after the address.

Function
REQ-021 The FSM SHALL have states IDLE, WRITE, RD_ISSUE and RD_DRAIN.
REQ-022 In IDLE, req_ready SHALL be 1; req_ready SHALL be 0 in every other state.
REQ-023 A request SHALL be accepted on a clock edge with req_valid&&req_ready; all request fields SHALL be latched at that edge.
REQ-024 Accepted stores SHALL go to WRITE; in the WRITE cycle mem_dwe=1, mem_addr=latched addr, mem_wdata=latched data; next state SHALL be IDLE; no response is generated.
REQ-025 Accepted loads SHALL go to RD_ISSUE; for len+1 consecutive cycles it SHALL drive mem_dwe=0 and mem_addr=(base+beat) mod 2^ADDR_W, with beat = 0..len.
REQ-026 After the last issue cycle the FSM SHALL go to RD_DRAIN, and return to IDLE once the last beat's resp_valid has been driven.
REQ-027 The beat issued in cycle k SHALL be captured from mem_rdata at the end of cycle k+1 and presented on resp_valid/resp_data in cycle k+2 (2-cycle issue-to-response latency; load accept-to-first-beat latency = 3 cycles).
REQ-028 Beats SHALL come out back-to-back, in address order; resp_last SHALL be 1 only on the final beat.
REQ-029 There SHALL be no response backpressure; the consumer always accepts.
REQ-030 mem_dwe SHALL be 1 only in WRITE.
REQ-031 mem_addr and mem_wdata SHALL hold their last values outside WRITE and RD_ISSUE.
REQ-032 busy SHALL be 1 from the edge after accept until the FSM is back in IDLE.
REQ-033 req_valid SHALL be ignored while req_ready=0.

Reset
REQ-034 While reset=1: state=IDLE, resp_valid=0, resp_last=0, resp_data=0, mem_dwe=0, mem_addr=0, mem_wdata=0, err=0, busy=0, and pipeline valid bits are cleared.
REQ-035 A reset during a burst SHALL discard all in-flight beats; no resp_valid SHALL appear after reset is released until a new request is accepted.

Configuration
REQ-036 With MEM_MASTER_BOUND_CHECK_EN defined, a request with any beat address >= MEM_DEPTH (64) SHALL be accepted but cause no memory write, no response, a single err pulse the cycle after accept, and a return to IDLE.
REQ-037 Without MEM_MASTER_BOUND_CHECK_EN, err SHALL be tied 0 and addresses wrap modulo 2^ADDR_W unchecked.

Structure
REQ-038 Package mem_master_pkg SHALL hold ADDR_W, DATA_W, LEN_W, MEM_DEPTH=64 and the FSM state typedef.
REQ-039 Sub-module mem_rd_pipe SHALL implement the 2-stage valid/last/data tracker for read beats.

Verification
REQ-040 Store 0x1234 @0x05, then load @0x05 len 0 -> mem_dwe pulses exactly 1 cycle; resp_data=0x1234, resp_last=1, 3 cycles after load accept.
REQ-041 After memory reset, burst load @0x00 len 7 -> 8 consecutive beats FFFE,FFFE,FFFE,0000,FFFF,FFFF,FFFF,0000; resp_last only on the 8th.
REQ-042 Build without the macro: load @0xFE len 3 -> mem_addr sequence FE,FF,00,01; err stays 0.
REQ-043 Build with the macro: load @0x3E len 3 -> no resp_valid, err=1 for 1 cycle, req_ready=1 two cycles after accept.
REQ-044 Assert reset in the 2nd beat of a len-7 burst -> all outputs go to 0 immediately; no resp_valid after release.
REQ-045 Hold req_valid=1 during a burst -> the second request is accepted only when req_ready returns to 1; no lost or duplicated beats.

Source files
------------

// File: rtl/mem_master_pkg.sv
// Shared widths, memory depth and FSM state type for the mem_master block.
package mem_master_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int LEN_W     = 3;
  localparam int MEM_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// Two-stage read-beat tracker: stage p0 waits for the registered memory,
// stage p1 holds the captured beat presented on the response port.
module mem_rd_pipe #(
  parameter int DATA_W = mem_master_pkg::DATA_W
) (
  input  logic              mem_clk,
  input  logic              reset,
  input  logic              issue_vld,
  input  logic              issue_last,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic              resp_last,
  output logic [DATA_W-1:0] resp_data,
  output logic              pending
);
  import mem_master_pkg::*;

  logic              vld_p0, last_p0;
  logic              vld_p1, last_p1;
  logic [DATA_W-1:0] data_p1;

  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      // p0: address issued last cycle, memory output valid now
      vld_p0  <= issue_vld;
      last_p0 <= issue_vld && issue_last;
      // p1: capture the beat for presentation
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      if (vld_p0) data_p1 <= mem_rdata;
    end
  end

  assign resp_valid = vld_p1;
  assign resp_last  = last_p1;
  assign resp_data  = data_p1;
  assign pending    = vld_p0 | vld_p1;

endmodule

// File: rtl/mem_master.sv
// Single-word store / burst load memory master with a 2-cycle read pipeline.
// Optional bound checking against MEM_DEPTH: define MEM_MASTER_BOUND_CHECK_EN.
module mem_master #(
  parameter int ADDR_W = mem_master_pkg::ADDR_W,
  parameter int DATA_W = mem_master_pkg::DATA_W,
  parameter int LEN_W  = mem_master_pkg::LEN_W
) (
  input  logic              mem_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              busy,
  output logic              err,
  output logic              mem_dwe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mem_master_pkg::*;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LEN_W-1:0]  len_q, beat_q;
  logic              err_q;
  logic              accept, bound_err;
  logic              issue_vld, issue_last, rd_pending;

  assign accept     = req_valid && (state == IDLE);
  assign issue_vld  = (state == RD_ISSUE);
  assign issue_last = (beat_q == len_q);

`ifdef MEM_MASTER_BOUND_CHECK_EN
  logic [ADDR_W:0] span_end;

  // Highest word touched by the request; stores touch only the base word
  always_comb begin
    span_end = {1'b0, req_addr};
    if (!req_we) span_end = span_end + (ADDR_W+1)'(req_len);
  end

  assign bound_err = accept && (int'(span_end) >= MEM_DEPTH);
`else
  assign bound_err = 1'b0;
`endif

  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= bound_err;
      if (accept && !bound_err) begin
        addr_q <= req_addr;
        len_q  <= req_len;
        beat_q <= '0;
        if (req_we) wdata_q <= req_wdata;
      end else if (issue_vld && !issue_last) begin
        // stop advancing on the final beat so mem_addr holds the last issued word
        addr_q <= addr_q + 1'b1;
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bound_err)   state_nxt = RD_DRAIN;
          else if (req_we) state_nxt = WRITE;
          else             state_nxt = RD_ISSUE;
        end
      end
      WRITE:    state_nxt = IDLE;
      RD_ISSUE: if (issue_last) state_nxt = RD_DRAIN;
      RD_DRAIN: if (!rd_pending || (resp_valid && resp_last)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  mem_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
    .mem_clk    (mem_clk),
    .reset      (reset),
    .issue_vld  (issue_vld),
    .issue_last (issue_last),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_last  (resp_last),
    .resp_data  (resp_data),
    .pending    (rd_pending)
  );

  assign req_ready = (state == IDLE);
  assign mem_dwe   = (state == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE) || rd_pending;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: directed and random requests against a
// transaction-level model of timing, addresses and memory contents.
module tb_mem_master;
  import mem_master_pkg::*;

  logic              mem_clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_last;
  logic              busy;
  logic              err;
  logic              mem_dwe;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  mem_master dut (
    .mem_clk    (mem_clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .busy       (busy),
    .err        (err),
    .mem_dwe    (mem_dwe),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 mem_clk = ~mem_clk;

  // Synchronous memory with registered read data
  logic [DATA_W-1:0] mem     [1<<ADDR_W];
  logic [DATA_W-1:0] ref_mem [1<<ADDR_W];

  always @(posedge mem_clk) begin
    if (mem_dwe) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    int                at;
    logic [ADDR_W-1:0] addr;
    bit                wr;
    logic [DATA_W-1:0] wd;
  } aev_t;

  typedef struct {
    int                at;
    logic [DATA_W-1:0] d;
    bit                last;
  } rev_t;

  aev_t              aq[$];
  rev_t              rq[$];
  int                cyc, free_at, err_at;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata;
  bit                wr_now;
  int                nerr, nchk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit out_of_bounds(input bit we, input int addr, input int len);
`ifdef MEM_MASTER_BOUND_CHECK_EN
    return we ? (addr >= MEM_DEPTH) : (addr + len >= MEM_DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_accept(input int a);
    logic [ADDR_W-1:0] ad;
    if (out_of_bounds(req_we, int'(req_addr), int'(req_len))) begin
      err_at  = a;
      free_at = a + 1;
    end else if (req_we) begin
      aq.push_back('{at: a, addr: req_addr, wr: 1'b1, wd: req_wdata});
      ref_mem[req_addr] = req_wdata;
      free_at = a + 1;
    end else begin
      for (int i = 0; i <= int'(req_len); i++) begin
        ad = req_addr + ADDR_W'(i);
        aq.push_back('{at: a + i, addr: ad, wr: 1'b0, wd: '0});
        rq.push_back('{at: a + 2 + i, d: ref_mem[ad], last: (i == int'(req_len))});
      end
      free_at = a + 3 + int'(req_len);
    end
  endtask

  task automatic apply_events();
    wr_now = 1'b0;
    while (aq.size() > 0 && aq[0].at == cyc) begin
      exp_addr = aq[0].addr;
      if (aq[0].wr) begin
        exp_wdata = aq[0].wd;
        wr_now    = 1'b1;
      end
      void'(aq.pop_front());
    end
  endtask

  task automatic check_cycle();
    bit rv;
    rv = (rq.size() > 0) && (rq[0].at == cyc);
    chk("req_ready", req_ready, cyc >= free_at);
    chk("busy", busy, cyc < free_at);
    chk("mem_dwe", mem_dwe, wr_now);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wdata", mem_wdata, exp_wdata);
    chk("err", err, cyc == err_at);
    chk("resp_valid", resp_valid, rv);
    if (rv) begin
      chk("resp_data", resp_data, rq[0].d);
      chk("resp_last", resp_last, rq[0].last);
      void'(rq.pop_front());
    end
  endtask

  task automatic tick(output bit acc);
    check_cycle();
    acc = req_valid && (cyc >= free_at);
    if (acc) model_accept(cyc + 1);
    @(posedge mem_clk);
    #1;
    cyc++;
    apply_events();
  endtask

  task automatic idle(input int n);
    bit acc;
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic issue(input bit we, input int addr, input int len, input logic [DATA_W-1:0] wd);
    bit acc;
    int n;
    req_we    = we;
    req_addr  = ADDR_W'(addr);
    req_len   = LEN_W'(len);
    req_wdata = wd;
    req_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 60) begin
      tick(acc);
      n++;
    end
    nchk++;
    assert (acc) else begin
      nerr++;
      $error("FAIL accept_timeout observed=%0d expected=1 (cycle %0d)", acc, cyc);
    end
  endtask

  task automatic clear_model();
    aq.delete();
    rq.delete();
    free_at   = cyc;
    err_at    = -1;
    exp_addr  = '0;
    exp_wdata = '0;
    wr_now    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_last"}, resp_last, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_mem_dwe"}, mem_dwe, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  logic [DATA_W-1:0] pattern [8];

  initial begin
    nerr = 0;
    nchk = 0;
    cyc  = 0;
    pattern = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'h0000,
                16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i]     = (i < 8) ? pattern[i] : DATA_W'($urandom);
      ref_mem[i] = mem[i];
    end

    // Power-on reset
    repeat (2) @(posedge mem_clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    clear_model();

    // Burst load over the freshly initialised memory, then store/load round trip
    idle(2);
    issue(1'b0, 'h00, 7, '0);
    idle(12);
    issue(1'b1, 'h05, 0, 16'h1234);
    issue(1'b0, 'h05, 0, '0);
    idle(6);

    // Address wrap (or bound violation when checking is built in)
`ifdef MEM_MASTER_BOUND_CHECK_EN
    issue(1'b0, 'h3E, 3, '0);
    idle(4);
    issue(1'b1, 'h40, 0, 16'hBEEF);
    idle(4);
`else
    issue(1'b0, 'hFE, 3, '0);
    idle(8);
`endif

    // Request held valid across a busy burst
    issue(1'b0, 'h10, 7, '0);
    issue(1'b0, 'h20, 2, '0);
    issue(1'b1, 'h21, 0, 16'hA5A5);
    issue(1'b0, 'h20, 3, '0);
    idle(8);

    // Random traffic, some back-to-back with req_valid held
    for (int r = 0; r < 40; r++) begin
`ifdef MEM_MASTER_BOUND_CHECK_EN
      issue($urandom_range(0, 2) == 0, $urandom_range(0, 70), $urandom_range(0, 7), DATA_W'($urandom));
`else
      issue($urandom_range(0, 2) == 0, $urandom_range(0, 255), $urandom_range(0, 7), DATA_W'($urandom));
`endif
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(15);
    chk("drained", rq.size(), 0);

    // Reset in the middle of a burst discards in-flight beats
    issue(1'b0, 'h08, 7, '0);
    idle(2);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge mem_clk);
    #1;
    reset = 1'b0;
    cyc++;
    clear_model();
    idle(12);
    issue(1'b0, 'h02, 1, '0);
    idle(6);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
